// File: rtl/sram_word_bridge_pkg.sv
// Shared types, default address map and helpers for the Retro16 SRAM word bridge.
package retro16_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_GAP,
    ST_IO_ACK
  } state_t;

  typedef enum logic [1:0] {
    REG_SRAM,
    REG_IO,
    REG_VRAM
  } region_t;

  localparam int unsigned DEF_IO_BASE   = 32'h0000_C000;
  localparam int unsigned DEF_VRAM_BASE = 32'h0000_F82F;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_word_bridge_decode.sv
// Combinational word-address to memory-region decode (SRAM / I/O window / video RAM).
module mem_region_decode
  import retro16_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned IO_BASE   = DEF_IO_BASE,
  parameter int unsigned VRAM_BASE = DEF_VRAM_BASE
) (
  input  logic [ADDR_W-1:0] i_addr,
  output region_t           o_region
);

  logic [31:0] w_addr;

  assign w_addr = 32'(i_addr);

  always_comb begin
    o_region = REG_SRAM;
    if (w_addr >= VRAM_BASE)    o_region = REG_VRAM;
    else if (w_addr >= IO_BASE) o_region = REG_IO;
  end

endmodule

// File: rtl/sram_word_bridge.sv
// CPU word bus to byte-wide async SRAM bridge with wait states, big-endian lane split,
// an I/O hole and write-only video-RAM forwarding.
module sram_word_bridge
  import retro16_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SRAM_DATA_W = 8,
  parameter int unsigned SRAM_ADDR_W = 21,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned IO_BASE     = DEF_IO_BASE,
  parameter int unsigned VRAM_BASE   = DEF_VRAM_BASE,
  parameter int unsigned VRAM_ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ack,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [SRAM_DATA_W-1:0] sram_data,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0]      vram_data,
  output logic                   vram_we
);

  localparam int unsigned R         = DATA_W / SRAM_DATA_W;
  localparam int unsigned LANE_BITS = clog2(R);
  localparam int unsigned LANE_CW   = (LANE_BITS == 0) ? 1 : LANE_BITS;
  localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(R - 1);
  localparam logic [3:0]         LAST_WAIT = 4'(WAIT_STATES);

  if (DATA_W % SRAM_DATA_W != 0) begin : g_chk_lanes
    $error("DATA_W must be a multiple of SRAM_DATA_W");
  end
  if (SRAM_ADDR_W < ADDR_W + LANE_BITS) begin : g_chk_addr
    $error("SRAM_ADDR_W too narrow for ADDR_W plus lane bits");
  end
  if (WAIT_STATES > 15) begin : g_chk_wait
    $error("WAIT_STATES must be 0..15");
  end

  state_t                 r_state, w_state_nxt;
  logic [LANE_CW-1:0]     r_lane, w_lane_nxt;
  logic [3:0]             r_wait, w_wait_nxt;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_we;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_rbuf, r_rdata;
  logic                   r_ack, r_ce_n, r_oe_n, r_we_n, r_drive;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [SRAM_DATA_W-1:0] r_wbyte;
  logic [VRAM_ADDR_W-1:0] r_vram_addr;
  logic [DATA_W-1:0]      r_vram_data;
  logic                   r_vram_we;

  region_t                w_region;
  logic                   w_accept, w_capture, w_we_cur;
  logic [ADDR_W-1:0]      w_addr_cur;
  logic [DATA_W-1:0]      w_wdata_cur, w_rd_word;
  logic [SRAM_DATA_W-1:0] w_wbyte_nxt;
  logic [SRAM_ADDR_W-1:0] w_byte_addr;

  // Decoding the live addr only matters at accept, where it equals the latched value.
  mem_region_decode #(
    .ADDR_W   (ADDR_W),
    .IO_BASE  (IO_BASE),
    .VRAM_BASE(VRAM_BASE)
  ) u_decode (
    .i_addr  (addr),
    .o_region(w_region)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_wait_nxt  = r_wait;
    w_accept    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_lane_nxt  = '0;
          w_wait_nxt  = '0;
          w_state_nxt = (w_region == REG_SRAM) ? ST_ACCESS : ST_IO_ACK;
        end
      end
      ST_ACCESS: begin
        if (r_wait == LAST_WAIT) begin
          w_state_nxt = ST_GAP;
          w_wait_nxt  = '0;
        end else begin
          w_wait_nxt = r_wait + 4'd1;
        end
      end
      ST_GAP: begin
        if (r_lane == LAST_LANE) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACCESS;
          w_lane_nxt  = r_lane + LANE_CW'(1);
        end
      end
      ST_IO_ACK: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_we_cur    = w_accept ? we    : r_we;
  assign w_addr_cur  = w_accept ? addr  : r_addr;
  assign w_wdata_cur = w_accept ? wdata : r_wdata;
  assign w_byte_addr = (SRAM_ADDR_W'(w_addr_cur) << LANE_BITS) | SRAM_ADDR_W'(w_lane_nxt);
  assign w_capture   = (r_state == ST_ACCESS) && !r_we && (r_wait == LAST_WAIT);

  // Lane k maps to the k-th most significant byte of the word.
  always_comb begin
    w_wbyte_nxt = '0;
    w_rd_word   = r_rbuf;
    for (int unsigned i = 0; i < R; i++) begin
      if (w_lane_nxt == LANE_CW'(i))
        w_wbyte_nxt = w_wdata_cur[DATA_W-1-i*SRAM_DATA_W -: SRAM_DATA_W];
      if (r_lane == LANE_CW'(i))
        w_rd_word[DATA_W-1-i*SRAM_DATA_W -: SRAM_DATA_W] = sram_data;
    end
  end

  // Outputs are registered from next-state values so the SRAM strobes are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lane      <= '0;
      r_wait      <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_rbuf      <= '0;
      r_rdata     <= '0;
      r_ack       <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_drive     <= 1'b0;
      r_sram_addr <= '0;
      r_wbyte     <= '0;
      r_vram_addr <= '0;
      r_vram_data <= '0;
      r_vram_we   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
      r_wait  <= w_wait_nxt;
      if (w_accept) begin
        r_addr  <= addr;
        r_we    <= we;
        r_wdata <= wdata;
      end
      r_ce_n  <= (w_state_nxt != ST_ACCESS);
      r_oe_n  <= !((w_state_nxt == ST_ACCESS) && !w_we_cur);
      r_we_n  <= !((w_state_nxt == ST_ACCESS) && w_we_cur);
      r_drive <= ((w_state_nxt == ST_ACCESS) || (w_state_nxt == ST_GAP)) && w_we_cur;
      if (w_state_nxt == ST_ACCESS) begin
        r_sram_addr <= w_byte_addr;
        r_wbyte     <= w_wbyte_nxt;
      end
      r_ack <= (w_state_nxt == ST_IO_ACK) ||
               ((w_state_nxt == ST_GAP) && (w_lane_nxt == LAST_LANE));
      if (w_capture) begin
        r_rbuf <= w_rd_word;
        if (r_lane == LAST_LANE) r_rdata <= w_rd_word;
      end else if (w_accept && (w_region != REG_SRAM) && !we) begin
        r_rdata <= '0;
      end
      r_vram_we <= w_accept && (w_region == REG_VRAM) && we;
      if (w_accept && (w_region == REG_VRAM) && we) begin
        r_vram_addr <= VRAM_ADDR_W'(32'(addr) - VRAM_BASE);
        r_vram_data <= wdata;
      end
    end
  end

  assign sram_data = r_drive ? r_wbyte : 'z;
  assign rdata     = r_rdata;
  assign ack       = r_ack;
  assign sram_addr = r_sram_addr;
  assign sram_ce_n = r_ce_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;
  assign vram_addr = r_vram_addr;
  assign vram_data = r_vram_data;
  assign vram_we   = r_vram_we;

endmodule

// File: tb/tb_sram_word_bridge.sv
// Directed bench for sram_word_bridge: default instance plus a zero-wait-state instance.
`timescale 1ns/1ps
module tb_sram_word_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned bfm_errs = 0;

  logic        req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] rdata, vram_data;
  logic        ack, ce_n, oe_n, we_n, vram_we;
  logic [20:0] sram_addr;
  logic [11:0] vram_addr;
  wire  [7:0]  sram_data;
  logic [7:0]  mem [4096];

  logic        req0 = 1'b0, we_in0 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0;
  logic [15:0] rdata0, vram_data0;
  logic        ack0, ce0, oe0, we0n, vram_we0;
  logic [20:0] sram_addr0;
  logic [11:0] vram_addr0;
  wire  [7:0]  sram_data0;

  sram_word_bridge #(.WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we)
  );

  sram_word_bridge #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we_in0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .sram_addr(sram_addr0), .sram_data(sram_data0),
    .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0n),
    .vram_addr(vram_addr0), .vram_data(vram_data0), .vram_we(vram_we0)
  );

  // SRAM models: memory-backed for the main instance, address pattern for the zero-wait one.
  assign sram_data  = (!ce_n && !oe_n) ? mem[sram_addr[11:0]] : 8'bz;
  assign sram_data0 = (!ce0 && !oe0) ? (sram_addr0[7:0] + 8'h11) : 8'bz;

  always @(negedge clk) begin
    if (rst_n && !ce_n && !we_n) mem[sram_addr[11:0]] <= sram_data;
    if (rst_n && (we_n === 1'b0) && (oe_n === 1'b0)) begin
      bfm_errs++;
      $display("FAIL bfm_we_oe_overlap: got we_n=0 oe_n=0 want never both low");
    end
    if (rst_n && (we0n === 1'b0) && (oe0 === 1'b0)) begin
      bfm_errs++;
      $display("FAIL bfm0_we_oe_overlap: got we_n=0 oe_n=0 want never both low");
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if ({ce_n, oe_n, we_n} !== 3'b111) begin fails++; $display("FAIL rst_strobes: got %b want 111", {ce_n, oe_n, we_n}); end
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL rst_ack: got %b want 0", ack); end
    tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
    tests++; if (sram_addr !== 21'h0) begin fails++; $display("FAIL rst_sram_addr: got %h want 0", sram_addr); end
    tests++; if ({vram_we, vram_addr, vram_data} !== 29'h0) begin fails++; $display("FAIL rst_vram: got %b/%h/%h want 0/000/0000", vram_we, vram_addr, vram_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_sram_write();
    logic exp_lo;
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 16'h0200; wdata = 16'h1234;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      exp_lo = (n == 1 || n == 2 || n == 4 || n == 5);
      tests++; if (we_n !== !exp_lo) begin fails++; $display("FAIL wr_we_n c%0d: got %b want %b", n, we_n, !exp_lo); end
      tests++; if (ce_n !== !exp_lo) begin fails++; $display("FAIL wr_ce_n c%0d: got %b want %b", n, ce_n, !exp_lo); end
      tests++; if (oe_n !== 1'b1) begin fails++; $display("FAIL wr_oe_n c%0d: got %b want 1", n, oe_n); end
      tests++; if (ack !== (n == 6)) begin fails++; $display("FAIL wr_ack c%0d: got %b want %b", n, ack, (n == 6)); end
      if (n <= 3) begin
        tests++; if (sram_data !== 8'h12) begin fails++; $display("FAIL wr_data0 c%0d: got %h want 12", n, sram_data); end
        tests++; if (sram_addr !== 21'h000400) begin fails++; $display("FAIL wr_addr0 c%0d: got %h want 000400", n, sram_addr); end
      end else if (n <= 6) begin
        tests++; if (sram_data !== 8'h34) begin fails++; $display("FAIL wr_data1 c%0d: got %h want 34", n, sram_data); end
        tests++; if (sram_addr !== 21'h000401) begin fails++; $display("FAIL wr_addr1 c%0d: got %h want 000401", n, sram_addr); end
      end
      if (n == 2) begin addr = 16'hFFFF; wdata = 16'hDEAD; end
      if (n == 6) req = 1'b0;
    end
  endtask

  task automatic test_sram_read();
    logic exp_lo;
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 16'h0200;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      exp_lo = (n == 1 || n == 2 || n == 4 || n == 5);
      tests++; if (oe_n !== !exp_lo) begin fails++; $display("FAIL rd_oe_n c%0d: got %b want %b", n, oe_n, !exp_lo); end
      tests++; if (we_n !== 1'b1) begin fails++; $display("FAIL rd_we_n c%0d: got %b want 1", n, we_n); end
      tests++; if (ack !== (n == 6)) begin fails++; $display("FAIL rd_ack c%0d: got %b want %b", n, ack, (n == 6)); end
      tests++; if (rdata !== ((n >= 6) ? 16'h1234 : 16'h0000)) begin fails++; $display("FAIL rd_rdata c%0d: got %h want %h", n, rdata, (n >= 6) ? 16'h1234 : 16'h0000); end
      if (exp_lo) begin
        tests++; if (sram_addr !== ((n < 3) ? 21'h000400 : 21'h000401)) begin fails++; $display("FAIL rd_addr c%0d: got %h", n, sram_addr); end
      end
      if (n == 6) req = 1'b0;
    end
  endtask

  task automatic test_vram_write();
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 16'hF830; wdata = 16'h0759;
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      tests++; if (ack !== (n == 1)) begin fails++; $display("FAIL vw_ack c%0d: got %b want %b", n, ack, (n == 1)); end
      tests++; if (vram_we !== (n == 1)) begin fails++; $display("FAIL vw_we c%0d: got %b want %b", n, vram_we, (n == 1)); end
      tests++; if (ce_n !== 1'b1) begin fails++; $display("FAIL vw_ce_n c%0d: got %b want 1", n, ce_n); end
      if (n == 1) begin
        tests++; if (vram_addr !== 12'h001) begin fails++; $display("FAIL vw_addr: got %h want 001", vram_addr); end
        tests++; if (vram_data !== 16'h0759) begin fails++; $display("FAIL vw_data: got %h want 0759", vram_data); end
        req = 1'b0;
      end
    end
  endtask

  task automatic test_vram_read_boundary();
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 16'hF82F;
    @(negedge clk);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL vr_ack: got %b want 1", ack); end
    tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL vr_rdata: got %h want 0000", rdata); end
    tests++; if (vram_we !== 1'b0) begin fails++; $display("FAIL vr_vram_we: got %b want 0", vram_we); end
    tests++; if (ce_n !== 1'b1) begin fails++; $display("FAIL vr_ce_n: got %b want 1", ce_n); end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_protocol_violation();
    logic exp_lo;
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 16'h0201; wdata = 16'h5566;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) req = 1'b0;
      exp_lo = (n == 1 || n == 2 || n == 4 || n == 5);
      tests++; if (we_n !== !exp_lo) begin fails++; $display("FAIL pv_we_n c%0d: got %b want %b", n, we_n, !exp_lo); end
      tests++; if (ack !== (n == 6)) begin fails++; $display("FAIL pv_ack c%0d: got %b want %b", n, ack, (n == 6)); end
      if (n == 4) begin
        tests++; if ({sram_addr, sram_data} !== {21'h000403, 8'h66}) begin fails++; $display("FAIL pv_lane1: got %h/%h want 000403/66", sram_addr, sram_data); end
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 16'h0300; wdata = 16'hABCD;
    repeat (4) @(negedge clk);
    tests++; if ({we_n, sram_addr} !== {1'b0, 21'h000601}) begin fails++; $display("FAIL mr_pre: got we_n=%b addr=%h want 0/000601", we_n, sram_addr); end
    rst_n = 1'b0;
    #1;
    tests++; if ({ce_n, oe_n, we_n} !== 3'b111) begin fails++; $display("FAIL mr_strobes: got %b want 111", {ce_n, oe_n, we_n}); end
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL mr_ack: got %b want 0", ack); end
    tests++; if (sram_addr !== 21'h0) begin fails++; $display("FAIL mr_sram_addr: got %h want 0", sram_addr); end
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req = 1'b1; we = 1'b0; addr = 16'h0200;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      tests++; if (ack !== (n == 6)) begin fails++; $display("FAIL mr_rd_ack c%0d: got %b want %b", n, ack, (n == 6)); end
      if (n == 6) begin
        tests++; if (rdata !== 16'h1234) begin fails++; $display("FAIL mr_rd_rdata: got %h want 1234", rdata); end
        req = 1'b0;
      end
    end
  endtask

  task automatic test_io_region();
    @(negedge clk); req = 1'b1; we = 1'b0; addr = 16'hC000;
    @(negedge clk);
    tests++; if ({ack, rdata} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL io_rd: got ack=%b rdata=%h want 1/0000", ack, rdata); end
    tests++; if (ce_n !== 1'b1) begin fails++; $display("FAIL io_rd_ce_n: got %b want 1", ce_n); end
    we = 1'b1; addr = 16'hC100; wdata = 16'hBEEF;
    @(negedge clk);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL io_gap_ack: got %b want 0", ack); end
    @(negedge clk);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL io_wr_ack: got %b want 1", ack); end
    tests++; if ({vram_we, ce_n, we_n} !== 3'b011) begin fails++; $display("FAIL io_wr_side: got %b want 011", {vram_we, ce_n, we_n}); end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sram_top_boundary();
    @(negedge clk); req = 1'b1; we = 1'b1; addr = 16'hBFFF; wdata = 16'h9AA9;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) begin
        tests++; if ({ce_n, we_n, sram_addr} !== {2'b00, 21'h017FFE}) begin fails++; $display("FAIL bnd_lane0: got %b%b/%h want 00/017FFE", ce_n, we_n, sram_addr); end
      end
      if (n == 6) begin
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL bnd_ack: got %b want 1", ack); end
        req = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_rd [3];
    int m, k;
    exp_rd[0] = 16'h3132; exp_rd[1] = 16'h3334; exp_rd[2] = 16'h3536;
    @(negedge clk); req0 = 1'b1; addr0 = 16'h0010;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      m = n % 5;
      k = (n - 1) / 5;
      tests++; if (oe0 !== !(m == 1 || m == 3)) begin fails++; $display("FAIL b2b_oe_n c%0d: got %b want %b", n, oe0, !(m == 1 || m == 3)); end
      tests++; if (ack0 !== (m == 4)) begin fails++; $display("FAIL b2b_ack c%0d: got %b want %b", n, ack0, (m == 4)); end
      if (m == 1 || m == 3) begin
        tests++; if (sram_addr0 !== 21'((16'h0010 + k) * 2 + ((m == 3) ? 1 : 0))) begin fails++; $display("FAIL b2b_addr c%0d: got %h", n, sram_addr0); end
      end
      if (m == 4) begin
        tests++; if (rdata0 !== exp_rd[k]) begin fails++; $display("FAIL b2b_rdata c%0d: got %h want %h", n, rdata0, exp_rd[k]); end
        addr0 = 16'(16'h0011 + k);
        if (k == 2) req0 = 1'b0;
      end
    end
    tests++; if (vram_we0 !== 1'b0) begin fails++; $display("FAIL b2b_vram_we: got %b want 0", vram_we0); end
  endtask

  task automatic test_bfm();
    tests++; if (bfm_errs !== 0) begin fails++; $display("FAIL bfm_total: got %0d violations want 0", bfm_errs); end
  endtask

  initial begin
    test_reset();
    test_sram_write();
    test_sram_read();
    test_vram_write();
    test_vram_read_boundary();
    test_protocol_violation();
    test_mid_reset();
    test_io_region();
    test_sram_top_boundary();
    test_back_to_back();
    test_bfm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
